// File: rtl/nco_lut_scheduler_pkg.sv
// Shared definitions for the quadrature NCO LUT scheduler: default widths,
// FSM state encoding and the quarter-wave LUT address offset.
package nco_lut_scheduler_pkg;

    localparam int PHASE_WIDTH_DEF = 24;
    localparam int LUT_DEPTH_DEF   = 8;
    localparam int DATA_WIDTH_DEF  = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOK_Q = 2'd1,
        LOOK_I = 2'd2,
        OUT    = 2'd3
    } nco_state_t;

    // +90 degrees expressed in LUT address steps for a given address width.
    function automatic int quarter_offset(input int depth);
        return 1 << (depth - 2);
    endfunction

    localparam int QUARTER_OFFSET = quarter_offset(LUT_DEPTH_DEF);

endpackage

// File: rtl/nco_lut_scheduler_phase_accum.sv
// Phase accumulator with a shadow/active tuning word pair so frequency
// changes land on a sample boundary and stay phase-continuous.
module nco_phase_accum
    import nco_lut_scheduler_pkg::*;
#(
    parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int LUT_DEPTH   = LUT_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PHASE_WIDTH-1:0] tuning_word,
    input  logic                   tuning_load,
    input  logic                   advance,
    input  logic                   transfer,
    output logic [LUT_DEPTH-1:0]   phase_msb
);

    logic [PHASE_WIDTH-1:0] phase_acc;
    logic [PHASE_WIDTH-1:0] tw_shadow;
    logic [PHASE_WIDTH-1:0] tw_active;

    // NOTE: non-blocking updates mean a load and a transfer in the same cycle
    // move the old shadow into the active word; the new word waits a sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_acc <= '0;
            tw_shadow <= '0;
            tw_active <= '0;
        end else begin
            if (tuning_load) tw_shadow <= tuning_word;
            if (advance)     phase_acc <= phase_acc + tw_active;
            if (transfer)    tw_active <= tw_shadow;
        end
    end

    assign phase_msb = phase_acc[PHASE_WIDTH-1 -: LUT_DEPTH];

endmodule

// File: rtl/nco_lut_scheduler.sv
// Quadrature NCO controller: time-shares one sine LUT for the sine and the
// +90 degree cosine lookup, then offers the I/Q pair on a valid/ready port.
module nco_lut_scheduler
    import nco_lut_scheduler_pkg::*;
#(
    parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int LUT_DEPTH   = LUT_DEPTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         sample_tick,
    input  logic [PHASE_WIDTH-1:0]       tuning_word,
    input  logic                         tuning_load,
    output logic [LUT_DEPTH-1:0]         lut_addr,
    input  logic signed [DATA_WIDTH-1:0] lut_data,
    output logic signed [DATA_WIDTH-1:0] i_data,
    output logic signed [DATA_WIDTH-1:0] q_data,
    output logic                         iq_valid,
    input  logic                         iq_ready,
    output logic                         overrun,
    input  logic                         overrun_clr
);

    localparam logic [LUT_DEPTH-1:0] QUARTER = LUT_DEPTH'(quarter_offset(LUT_DEPTH));

    nco_state_t           state;
    logic [LUT_DEPTH-1:0] phase_msb;
    logic                 tick_en;
    logic                 accept;
    logic                 busy_tick;

    assign tick_en   = enable && sample_tick;
    assign accept    = tick_en && (state == IDLE);
    assign busy_tick = tick_en && (state != IDLE);

    // Busy ticks still advance the phase so the output frequency stays exact.
    nco_phase_accum #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .LUT_DEPTH   (LUT_DEPTH)
    ) u_phase (
        .clk         (clk),
        .rst_n       (rst_n),
        .tuning_word (tuning_word),
        .tuning_load (tuning_load),
        .advance     (tick_en),
        .transfer    (accept),
        .phase_msb   (phase_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lut_addr <= '0;
            i_data   <= '0;
            q_data   <= '0;
            iq_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lut_addr <= phase_msb;
                        state    <= LOOK_Q;
                    end
                end
                LOOK_Q: begin
                    q_data   <= lut_data;
                    lut_addr <= lut_addr + QUARTER;
                    state    <= LOOK_I;
                end
                LOOK_I: begin
                    i_data   <= lut_data;
                    iq_valid <= 1'b1;
                    state    <= OUT;
                end
                OUT: begin
                    if (iq_valid && iq_ready) begin
                        iq_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                // NOTE: all four encodings are used; the default only keeps the
                // case total so no state-holding logic is inferred by accident.
                default: state <= IDLE;
            endcase
        end
    end

    // A dropped sample outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (busy_tick) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nco_lut_scheduler.sv
// Bench for nco_lut_scheduler: drives a sine LUT model and compares each
// I/Q pair against a sample-level phase model.
module tb_nco_lut_scheduler;
    import nco_lut_scheduler_pkg::*;

    localparam int PW = 24;
    localparam int LD = 8;
    localparam int DW = 7;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic                 sample_tick;
    logic [PW-1:0]        tuning_word;
    logic                 tuning_load;
    logic [LD-1:0]        lut_addr;
    logic signed [DW-1:0] lut_data;
    logic signed [DW-1:0] i_data;
    logic signed [DW-1:0] q_data;
    logic                 iq_valid;
    logic                 iq_ready;
    logic                 overrun;
    logic                 overrun_clr;

    logic signed [DW-1:0] sine_lut [256];

    int checks   = 0;
    int failures = 0;

    // Sample-level reference state.
    logic [PW-1:0]        m_phase;
    logic [PW-1:0]        m_tw_act;
    logic [PW-1:0]        m_tw_sh;
    bit                   m_busy;
    int                   m_age;
    bit                   m_ovr;
    logic signed [DW-1:0] m_exp_i;
    logic signed [DW-1:0] m_exp_q;

    always #5 clk = ~clk;

    assign lut_data = sine_lut[lut_addr];

    nco_lut_scheduler #(
        .PHASE_WIDTH (PW),
        .LUT_DEPTH   (LD),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sample_tick (sample_tick),
        .tuning_word (tuning_word),
        .tuning_load (tuning_load),
        .lut_addr    (lut_addr),
        .lut_data    (lut_data),
        .i_data      (i_data),
        .q_data      (q_data),
        .iq_valid    (iq_valid),
        .iq_ready    (iq_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    function automatic logic signed [DW-1:0] exp_sin(input logic [LD-1:0] a);
        return sine_lut[a];
    endfunction

    function automatic logic signed [DW-1:0] exp_cos(input logic [LD-1:0] a);
        logic [LD-1:0] b;
        b = a + LD'(QUARTER_OFFSET);
        return sine_lut[b];
    endfunction

    task automatic model_reset();
        m_phase = '0; m_tw_act = '0; m_tw_sh = '0;
        m_busy = 0; m_age = 0; m_ovr = 0;
        m_exp_i = '0; m_exp_q = '0;
    endtask

    // Drive one clock cycle of inputs and advance the reference by one cycle.
    task automatic step(input bit en, input bit tick, input bit load,
                        input logic [PW-1:0] word, input bit ready, input bit clr);
        bit acc, bt, hs;
        @(negedge clk);
        enable = en; sample_tick = tick; tuning_load = load;
        tuning_word = word; iq_ready = ready; overrun_clr = clr;
        acc = en && tick && !m_busy;
        bt  = en && tick && m_busy;
        hs  = m_busy && (m_age >= 3) && ready;
        if (acc) begin
            m_exp_q  = exp_sin(m_phase[PW-1 -: LD]);
            m_exp_i  = exp_cos(m_phase[PW-1 -: LD]);
            m_phase  = m_phase + m_tw_act;
            m_tw_act = m_tw_sh;
            m_busy   = 1;
            m_age    = 1;
        end else begin
            if (bt) m_phase = m_phase + m_tw_act;
            if (hs) m_busy = 0;
            else if (m_busy) m_age++;
        end
        if (bt) m_ovr = 1;
        else if (clr) m_ovr = 0;
        if (load) m_tw_sh = word;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(1, 0, 0, '0, 1, 0);
    endtask

    // One accepted tick followed by a bounded wait for the resulting pair.
    task automatic collect_sample(input bit load, input logic [PW-1:0] word,
                                  output logic signed [DW-1:0] oi,
                                  output logic signed [DW-1:0] oq, output bit got);
        got = 0; oi = '0; oq = '0;
        step(1, 1, load, word, 1, 0);
        for (int k = 0; k < 8; k++) begin
            idle_step();
            if (iq_valid === 1'b1) begin
                oi = i_data; oq = q_data; got = 1;
                idle_step();
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (lut_addr !== 8'd0) begin failures++; $display("FAIL reset_lut_addr got=%0d exp=0", lut_addr); end
        checks++; if (i_data !== 7'sd0) begin failures++; $display("FAIL reset_i got=%0d exp=0", i_data); end
        checks++; if (q_data !== 7'sd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q_data); end
        checks++; if (iq_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", iq_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    endtask

    task automatic test_single();
        step(1, 1, 0, '0, 1, 0);
        checks++; if (lut_addr !== 8'd0) begin failures++; $display("FAIL single_addr_sin got=%0d exp=0", lut_addr); end
        checks++; if (iq_valid !== 1'b0) begin failures++; $display("FAIL single_valid_t1 got=%0b exp=0", iq_valid); end
        idle_step();
        checks++; if (lut_addr !== 8'd64) begin failures++; $display("FAIL single_addr_cos got=%0d exp=64", lut_addr); end
        checks++; if (iq_valid !== 1'b0) begin failures++; $display("FAIL single_valid_t2 got=%0b exp=0", iq_valid); end
        idle_step();
        checks++; if (iq_valid !== 1'b1) begin failures++; $display("FAIL single_valid_t3 got=%0b exp=1", iq_valid); end
        checks++; if (q_data !== 7'sd0) begin failures++; $display("FAIL single_q got=%0d exp=0", q_data); end
        checks++; if (i_data !== 7'sd63) begin failures++; $display("FAIL single_i got=%0d exp=63", i_data); end
        idle_step();
        checks++; if (iq_valid !== 1'b0) begin failures++; $display("FAIL single_accept got=%0b exp=0", iq_valid); end
    endtask

    task automatic test_sweep();
        logic signed [DW-1:0] ei [5];
        logic signed [DW-1:0] eq [5];
        logic [LD-1:0]        ea [5];
        ei = '{7'sd63, 7'sd63, 7'sd0, -7'sd63, 7'sd0};
        eq = '{7'sd0, 7'sd0, 7'sd63, 7'sd0, -7'sd63};
        ea = '{8'd64, 8'd64, 8'd128, 8'd192, 8'd0};
        step(1, 0, 1, 24'h400000, 1, 0);
        for (int n = 0; n < 5; n++) begin
            step(1, 1, 0, '0, 1, 0);
            idle_step();
            checks++; if (lut_addr !== ea[n]) begin failures++; $display("FAIL sweep%0d_cos_addr got=%0d exp=%0d", n, lut_addr, ea[n]); end
            idle_step();
            checks++; if (iq_valid !== 1'b1) begin failures++; $display("FAIL sweep%0d_valid got=%0b exp=1", n, iq_valid); end
            checks++; if (i_data !== ei[n]) begin failures++; $display("FAIL sweep%0d_i got=%0d exp=%0d", n, i_data, ei[n]); end
            checks++; if (q_data !== eq[n]) begin failures++; $display("FAIL sweep%0d_q got=%0d exp=%0d", n, q_data, eq[n]); end
            repeat (3) idle_step();
        end
    endtask

    task automatic test_overrun();
        logic signed [DW-1:0] hi, hq, oi, oq;
        bit got;
        step(1, 1, 0, '0, 0, 0);
        step(1, 0, 0, '0, 0, 0);
        step(1, 0, 0, '0, 0, 0);
        checks++; if (iq_valid !== 1'b1) begin failures++; $display("FAIL ovr_first_valid got=%0b exp=1", iq_valid); end
        checks++; if (i_data !== m_exp_i) begin failures++; $display("FAIL ovr_first_i got=%0d exp=%0d", i_data, m_exp_i); end
        checks++; if (q_data !== m_exp_q) begin failures++; $display("FAIL ovr_first_q got=%0d exp=%0d", q_data, m_exp_q); end
        hi = m_exp_i; hq = m_exp_q;
        step(1, 1, 0, '0, 0, 0);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%0b exp=1", overrun); end
        checks++; if (iq_valid !== 1'b1) begin failures++; $display("FAIL ovr_hold_valid got=%0b exp=1", iq_valid); end
        checks++; if (i_data !== hi) begin failures++; $display("FAIL ovr_hold_i got=%0d exp=%0d", i_data, hi); end
        checks++; if (q_data !== hq) begin failures++; $display("FAIL ovr_hold_q got=%0d exp=%0d", q_data, hq); end
        step(1, 0, 0, '0, 1, 0);
        checks++; if (iq_valid !== 1'b0) begin failures++; $display("FAIL ovr_accept got=%0b exp=0", iq_valid); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
        step(1, 0, 0, '0, 1, 1);
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%0b exp=0", overrun); end
        // Tick during the handshake cycle is busy; it also beats a clear.
        step(1, 1, 0, '0, 0, 0);
        step(1, 0, 0, '0, 0, 0);
        step(1, 0, 0, '0, 0, 0);
        step(1, 1, 0, '0, 1, 1);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%0b exp=1", overrun); end
        checks++; if (iq_valid !== 1'b0) begin failures++; $display("FAIL ovr_handshake got=%0b exp=0", iq_valid); end
        step(1, 0, 0, '0, 1, 1);
        collect_sample(0, '0, oi, oq, got);
        checks++; if (!got) begin failures++; $display("FAIL ovr_resume_timeout got=0 exp=1"); end
        checks++; if (oi !== m_exp_i || oq !== m_exp_q) begin failures++; $display("FAIL ovr_resume_pair got=(%0d,%0d) exp=(%0d,%0d)", oi, oq, m_exp_i, m_exp_q); end
    endtask

    task automatic test_load_same_cycle();
        logic [PW-1:0]        p, a0, s0, w;
        logic [PW-1:0]        idx_phase [4];
        logic signed [DW-1:0] oi, oq;
        bit got;
        p  = m_phase; a0 = m_tw_act; s0 = m_tw_sh;
        w  = PW'($urandom);
        idx_phase[0] = p;
        idx_phase[1] = p + a0;
        idx_phase[2] = p + a0 + s0;
        idx_phase[3] = p + a0 + s0 + w;
        for (int n = 0; n < 4; n++) begin
            collect_sample(n == 0, w, oi, oq, got);
            checks++; if (!got) begin failures++; $display("FAIL load%0d_timeout got=0 exp=1", n); end
            checks++;
            if (oi !== exp_cos(idx_phase[n][PW-1 -: LD]) || oq !== exp_sin(idx_phase[n][PW-1 -: LD])) begin
                failures++;
                $display("FAIL load%0d_pair got=(%0d,%0d) exp=(%0d,%0d)", n, oi, oq,
                         exp_cos(idx_phase[n][PW-1 -: LD]), exp_sin(idx_phase[n][PW-1 -: LD]));
            end
        end
    endtask

    task automatic test_enable_low();
        logic [PW-1:0]        p;
        logic signed [DW-1:0] oi, oq;
        bit got;
        p = m_phase;
        for (int n = 0; n < 3; n++) begin
            step(0, 1, 0, '0, 1, 0);
            checks++; if (iq_valid !== 1'b0) begin failures++; $display("FAIL en_low%0d_valid got=%0b exp=0", n, iq_valid); end
            checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL en_low%0d_overrun got=%0b exp=0", n, overrun); end
        end
        collect_sample(0, '0, oi, oq, got);
        checks++; if (!got) begin failures++; $display("FAIL en_resume_timeout got=0 exp=1"); end
        checks++;
        if (oi !== exp_cos(p[PW-1 -: LD]) || oq !== exp_sin(p[PW-1 -: LD])) begin
            failures++;
            $display("FAIL en_resume_pair got=(%0d,%0d) exp=(%0d,%0d)", oi, oq, exp_cos(p[PW-1 -: LD]), exp_sin(p[PW-1 -: LD]));
        end
    endtask

    task automatic test_reset_mid();
        logic signed [DW-1:0] oi, oq;
        bit got;
        step(1, 1, 0, '0, 1, 0);
        idle_step();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (lut_addr !== 8'd0) begin failures++; $display("FAIL rst_mid_addr got=%0d exp=0", lut_addr); end
        checks++; if (i_data !== 7'sd0 || q_data !== 7'sd0) begin failures++; $display("FAIL rst_mid_iq got=(%0d,%0d) exp=(0,0)", i_data, q_data); end
        checks++; if (iq_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%0b exp=0", iq_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_mid_overrun got=%0b exp=0", overrun); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        collect_sample(0, '0, oi, oq, got);
        checks++; if (!got) begin failures++; $display("FAIL rst_after_timeout got=0 exp=1"); end
        checks++; if (oi !== 7'sd63 || oq !== 7'sd0) begin failures++; $display("FAIL rst_after_pair got=(%0d,%0d) exp=(63,0)", oi, oq); end
    endtask

    task automatic test_random();
        bit ev;
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, PW'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            ev = m_busy && (m_age >= 3);
            checks++; if (iq_valid !== ev) begin failures++; $display("FAIL rand%0d_valid got=%0b exp=%0b", c, iq_valid, ev); end
            checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL rand%0d_overrun got=%0b exp=%0b", c, overrun, m_ovr); end
            if (ev) begin
                checks++;
                if (i_data !== m_exp_i || q_data !== m_exp_q) begin
                    failures++;
                    $display("FAIL rand%0d_pair got=(%0d,%0d) exp=(%0d,%0d)", c, i_data, q_data, m_exp_i, m_exp_q);
                end
            end
        end
        idle_step();
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            real v;
            int  r;
            v = 63.0 * $sin(6.283185307179586 * a / 256.0);
            r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
            sine_lut[a] = DW'(r);
        end
        rst_n = 1'b0; enable = 1'b0; sample_tick = 1'b0; tuning_word = '0;
        tuning_load = 1'b0; iq_ready = 1'b1; overrun_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_single();
        test_sweep();
        test_overrun();
        test_load_same_cycle();
        test_enable_low();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
